// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared bus, CACHE-op and helper definitions for the instruction cache
package cache_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } ibus_resp_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef logic [3:0] mlen_t;
  localparam mlen_t MLEN1 = 4'd0;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    I_NONE            = 2'd0,
    I_INDEX_INVALID   = 2'd1,
    I_HIT_INVALID     = 2'd2,
    I_INDEX_STORE_TAG = 2'd3
  } icache_inst_t;

  typedef struct packed {
    logic [31:0] ptag;
    logic        v;
  } cp0_taglo_t;

  // kseg1 is the unmapped, uncached window
  function automatic logic is_uncached(input logic [31:0] addr);
    return addr[31:29] == 3'b101;
  endfunction

  function automatic mlen_t mlen_of(input int words);
    return mlen_t'(words - 1);
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// rtl/icache_line_ram.sv - SETS x LINE_WORDS word store, one write port, two async read ports
module icache_line_ram #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(SETS)-1:0]       widx,
  input  logic [$clog2(LINE_WORDS)-1:0] woff,
  input  logic [31:0]                   wdata,
  input  logic [$clog2(SETS)-1:0]       ridx0,
  input  logic [$clog2(LINE_WORDS)-1:0] roff0,
  output logic [31:0]                   rdata0,
  input  logic [$clog2(SETS)-1:0]       ridx1,
  input  logic [$clog2(LINE_WORDS)-1:0] roff1,
  output logic [31:0]                   rdata1
);

  logic [31:0] mem [SETS*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[{widx, woff}] <= wdata;
  end

  assign rdata0 = mem[{ridx0, roff0}];
  assign rdata1 = mem[{ridx1, roff1}];

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache returning a word pair per fetch
module icache_dm
  import cache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  ibus_req_t    ireq,
  output ibus_resp_t   iresp,
  output cbus_req_t    icreq,
  input  cbus_resp_t   icresp,
  input  icache_inst_t cache_inst,
  input  cp0_taglo_t   tag_lo
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, REFILL, UNCACHE_1, UNCACHE_2, RESP} state_t;

  state_t state, state_d;

  logic [31:0]      addr0, addr1;
  logic [IDX_W-1:0] idx0, idx1;
  logic [OFF_W-1:0] off0, off1;
  logic [TAG_W-1:0] tag0, tag1;
  logic             hit0, hit1;
  logic [31:0]      word0, word1;

  logic [TAG_W-1:0] tag_mem [SETS];
  logic [SETS-1:0]  valid_q;
  logic [63:0]      resp_q;
  logic [31:0]      lo_q;
  logic [OFF_W-1:0] beat_q;
  logic [IDX_W-1:0] fill_idx_q;
  logic [TAG_W-1:0] fill_tag_q;

  logic addr_ok, data_ok;
  logic cap_hit, cap_lo, cap_unc;
  logic start_fill, fill_done, ram_we;
  logic inst_inv, inst_store;

  logic unused;
  assign unused = ^{ireq.addr[1:0], tag_lo.ptag[31:TAG_W]};

  assign addr0 = {ireq.addr[31:2], 2'b00};
  assign addr1 = addr0 + 32'd4;
  assign idx0  = addr0[2+OFF_W +: IDX_W];
  assign idx1  = addr1[2+OFF_W +: IDX_W];
  assign off0  = addr0[2 +: OFF_W];
  assign off1  = addr1[2 +: OFF_W];
  assign tag0  = addr0[31 -: TAG_W];
  assign tag1  = addr1[31 -: TAG_W];
  assign hit0  = valid_q[idx0] && (tag_mem[idx0] == tag0);
  assign hit1  = valid_q[idx1] && (tag_mem[idx1] == tag1);

  assign ram_we    = (state == REFILL) && icresp.ready;
  assign fill_done = ram_we && icresp.last;

  icache_line_ram #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_line_ram (
    .clk    (clk),
    .we     (ram_we),
    .widx   (fill_idx_q),
    .woff   (beat_q),
    .wdata  (icresp.data),
    .ridx0  (idx0),
    .roff0  (off0),
    .rdata0 (word0),
    .ridx1  (idx1),
    .roff1  (off1),
    .rdata1 (word1)
  );

  always_comb begin
    state_d    = state;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    cap_hit    = 1'b0;
    cap_lo     = 1'b0;
    cap_unc    = 1'b0;
    start_fill = 1'b0;
    inst_inv   = 1'b0;
    inst_store = 1'b0;
    icreq      = '0;
    icreq.size = MSIZE4;
    case (state)
      IDLE: begin
        if (cache_inst != I_NONE) begin
          addr_ok = 1'b1;
          case (cache_inst)
            I_INDEX_INVALID:   inst_inv   = 1'b1;
            I_HIT_INVALID:     inst_inv   = hit0;
            I_INDEX_STORE_TAG: inst_store = 1'b1;
            default: ;
          endcase
        end else if (ireq.valid) begin
          if (is_uncached(addr0)) begin
            state_d = UNCACHE_1;
          end else if (hit0 && hit1) begin
            addr_ok = 1'b1;
            cap_hit = 1'b1;
            state_d = RESP;
          end else begin
            start_fill = 1'b1;
            state_d    = REFILL;
          end
        end
      end
      REFILL: begin
        icreq.valid = 1'b1;
        icreq.addr  = {fill_tag_q, fill_idx_q, {(OFF_W+2){1'b0}}};
        icreq.len   = mlen_of(LINE_WORDS);
        if (icresp.ready && icresp.last) state_d = IDLE;
      end
      UNCACHE_1: begin
        icreq.valid = 1'b1;
        icreq.addr  = addr0;
        icreq.len   = MLEN1;
        if (icresp.ready && icresp.last) begin
          cap_lo  = 1'b1;
          state_d = UNCACHE_2;
        end
      end
      UNCACHE_2: begin
        icreq.valid = 1'b1;
        icreq.addr  = addr1;
        icreq.len   = MLEN1;
        if (icresp.ready && icresp.last) begin
          addr_ok = 1'b1;
          cap_unc = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        data_ok = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    iresp         = '0;
    iresp.addr_ok = addr_ok;
    iresp.data_ok = data_ok;
    iresp.data    = (state == RESP) ? resp_q : 64'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      valid_q <= '0;
      resp_q  <= '0;
      beat_q  <= '0;
    end else begin
      state <= state_d;
      if (start_fill) beat_q <= '0;
      else if (ram_we) beat_q <= beat_q + 1'b1;
      if (fill_done) valid_q[fill_idx_q] <= 1'b1;
      if (inst_inv) valid_q[idx0] <= 1'b0;
      if (inst_store) valid_q[idx0] <= tag_lo.v;
      if (cap_hit) resp_q <= {word1, word0};
      if (cap_unc) resp_q <= {icresp.data, lo_q};
    end
  end

  // Fill target is the first missing line; the pair's second line follows on re-lookup
  always_ff @(posedge clk) begin
    if (start_fill) begin
      fill_idx_q <= hit0 ? idx1 : idx0;
      fill_tag_q <= hit0 ? tag1 : tag0;
    end
    if (cap_lo) lo_q <= icresp.data;
  end

  always_ff @(posedge clk) begin
    if (!reset && fill_done) tag_mem[fill_idx_q] <= fill_tag_q;
    else if (!reset && inst_store) tag_mem[idx0] <= tag_lo.ptag[TAG_W-1:0];
  end

endmodule
